// File: rtl/mpuf_response_ctrl.sv
// mpuf_response_ctrl: sequencer for a multi-level arbiter PUF with majority voting.
//
// A challenge is accepted, held on puf_chal and evaluated NV times. Each evaluation
// is PREP (delay lines held in reset), LAUNCH (one-cycle launch pulse), WAIT (SETTLE
// cycles for the arbiters to resolve) and SAMPLE (synchronised arbiter bits are
// counted). After NV votes the majority response is presented until it is accepted.
//
// Ports:
//   clk, clr             clock, asynchronous active-low reset
//   req_valid/req_ready  challenge request handshake; challenge captured on accept
//   puf_chal             registered challenge to all arbiter levels
//   puf_rst, puf_launch  delay line / arbiter clear and launch pulse
//   arb_in               raw arbiter outputs (asynchronous to clk)
//   resp_valid/ready     response handshake
//   resp, resp_stable    majority-voted response and per-bit unanimity mask
//
// Optional feature: define MPUF_STABILITY_EN to compute resp_stable from vote
// unanimity; otherwise resp_stable is simply all-ones in DONE.

module mpuf_response_ctrl #(
    parameter int unsigned CW     = 32,
    parameter int unsigned NL     = 4,
    parameter int unsigned NV     = 5,
    parameter int unsigned SETTLE = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] challenge,
    output logic [CW-1:0] puf_chal,
    output logic          puf_rst,
    output logic          puf_launch,
    input  logic [NL-1:0] arb_in,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [NL-1:0] resp,
    output logic [NL-1:0] resp_stable
);

    localparam int unsigned CntW  = $clog2(NV + 1);
    localparam int unsigned WaitW = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0] Half = CntW'(NV / 2);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StLaunch,
        StWait,
        StSample,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               chal_q, chal_d;
    logic [NL-1:0][CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]             vote_q, vote_d;
    logic [WaitW-1:0]            wait_q, wait_d;
    logic [NL-1:0]               resp_q, resp_d;
    logic [NL-1:0]               stable_q, stable_d;
    logic [NL-1:0]               arb_meta_q, arb_sync_q;
    logic                        rst_out_q, launch_q;

    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        cnt_d    = cnt_q;
        vote_d   = vote_q;
        wait_d   = wait_q;
        resp_d   = resp_q;
        stable_d = stable_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    chal_d  = challenge;
                    cnt_d   = '0;
                    vote_d  = '0;
                    state_d = StPrep;
                end
            end
            StPrep:   state_d = StLaunch;
            StLaunch: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == WaitW'(SETTLE - 1)) begin
                    state_d = StSample;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StSample: begin
                for (int i = 0; i < int'(NL); i++) begin
                    cnt_d[i] = cnt_q[i] + CntW'(arb_sync_q[i]);
                end
                vote_d = vote_q + 1'b1;
                if (vote_q == CntW'(NV - 1)) begin
                    state_d = StDone;
                    // Response is latched from the counts including this final vote.
                    for (int i = 0; i < int'(NL); i++) begin
                        resp_d[i] = cnt_d[i] > Half;
`ifdef MPUF_STABILITY_EN
                        stable_d[i] = (cnt_d[i] == '0) || (cnt_d[i] == CntW'(NV));
`endif
                    end
`ifndef MPUF_STABILITY_EN
                    stable_d = '1;
`endif
                end else begin
                    state_d = StPrep;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= StIdle;
            chal_q     <= '0;
            cnt_q      <= '0;
            vote_q     <= '0;
            wait_q     <= '0;
            resp_q     <= '0;
            stable_q   <= '0;
            arb_meta_q <= '0;
            arb_sync_q <= '0;
            rst_out_q  <= 1'b1;
            launch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            cnt_q      <= cnt_d;
            vote_q     <= vote_d;
            wait_q     <= wait_d;
            resp_q     <= resp_d;
            stable_q   <= stable_d;
            arb_meta_q <= arb_in;
            arb_sync_q <= arb_meta_q;
            // PUF-facing controls are registered so they cannot glitch on state decode.
            rst_out_q  <= (state_d == StIdle) || (state_d == StPrep) || (state_d == StDone);
            launch_q   <= (state_d == StLaunch);
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StDone);
    assign puf_chal    = chal_q;
    assign puf_rst     = rst_out_q;
    assign puf_launch  = launch_q;
    assign resp        = resp_q;
    assign resp_stable = stable_q;

endmodule

// File: tb/tb_mpuf_response_ctrl.sv
// Testbench for mpuf_response_ctrl: table of per-vote arbiter patterns with
// expected responses, a scoreboard queue of expected results, and hand-written
// sequences for backpressure and mid-evaluation reset.

module tb_mpuf_response_ctrl;

    localparam int unsigned CW = 32;
    localparam int unsigned NL = 4;
    localparam int unsigned NV = 5;
    localparam int unsigned SETTLE = 8;
    localparam int LATENCY = NV * (SETTLE + 3);

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] challenge = '0;
    logic [CW-1:0] puf_chal;
    logic          puf_rst;
    logic          puf_launch;
    logic [NL-1:0] arb_in = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [NL-1:0] resp;
    logic [NL-1:0] resp_stable;

    mpuf_response_ctrl #(
        .CW(CW), .NL(NL), .NV(NV), .SETTLE(SETTLE)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .challenge  (challenge),
        .puf_chal   (puf_chal),
        .puf_rst    (puf_rst),
        .puf_launch (puf_launch),
        .arb_in     (arb_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp       (resp),
        .resp_stable(resp_stable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0]          chal;
        logic [NV-1:0][NL-1:0]  pats;     // pats[v] is arb_in during vote v
        logic [NL-1:0]          exp_resp;
    } vec_t;

    typedef struct packed {
        logic [NL-1:0] r;
        logic [NL-1:0] s;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] model_stable(input logic [NV-1:0][NL-1:0] pats);
        logic [NL-1:0] s;
        int c;
        for (int i = 0; i < int'(NL); i++) begin
            c = 0;
            for (int v = 0; v < int'(NV); v++) c += int'(pats[v][i]);
`ifdef MPUF_STABILITY_EN
            s[i] = (c == 0) || (c == int'(NV));
`else
            s[i] = 1'b1;
`endif
        end
        return s;
    endfunction

    // Accept a challenge; returns the cycle count just after the accept edge.
    task automatic do_accept(input logic [CW-1:0] chal, output int c0);
        @(negedge clk);
        challenge = chal;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        challenge = ~chal;  // puf_chal must not follow the input after accept
        c0 = cyc;
    endtask

    // Wait for the next launch pulse, checking the preceding PREP cycle.
    task automatic wait_launch(input logic [CW-1:0] chal, input int v, output bit ok);
        logic prev_rst;
        int guard;
        prev_rst = puf_rst;
        guard = 0;
        ok = 1'b1;
        while (!puf_launch) begin
            prev_rst = puf_rst;
            @(negedge clk);
            guard++;
            if (guard > 4 * int'(SETTLE) + 20) begin
                check($sformatf("launch_timeout_v%0d", v), 32'd1, 32'd0);
                ok = 1'b0;
                return;
            end
        end
        check($sformatf("prep_rst_v%0d", v), {31'd0, prev_rst}, 32'd1);
        check($sformatf("launch_rst_v%0d", v), {31'd0, puf_rst}, 32'd0);
        check($sformatf("chal_v%0d", v), puf_chal, chal);
    endtask

    task automatic run_vector(input vec_t tv, input int id, input bit hold_test);
        int c0;
        int guard;
        bit ok;
        bit held_ok;
        logic [NL-1:0] r0, s0;
        exp_t e;
        arb_in = tv.pats[0];
        do_accept(tv.chal, c0);
        sb.push_back('{r: tv.exp_resp, s: model_stable(tv.pats)});
        for (int v = 0; v < int'(NV); v++) begin
            wait_launch(tv.chal, v, ok);
            if (!ok) return;
            arb_in = tv.pats[v];
            @(negedge clk);
            check($sformatf("launch_width_v%0d", v), {31'd0, puf_launch}, 32'd0);
        end
        guard = 0;
        while (!resp_valid && guard < 2 * LATENCY) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("latency_%0d", id), cyc - c0, LATENCY);
        e = sb.pop_front();
        check($sformatf("resp_%0d", id), {28'd0, resp}, {28'd0, e.r});
        check($sformatf("stable_%0d", id), {28'd0, resp_stable}, {28'd0, e.s});
        r0 = resp;
        s0 = resp_stable;
        if (hold_test) begin
            held_ok = 1'b1;
            for (int k = 0; k < 20; k++) begin
                req_valid = (k % 3 == 0);
                challenge = 32'hdead_0000 + k;
                @(negedge clk);
                if (!resp_valid || resp !== r0 || resp_stable !== s0 || req_ready
                    || puf_chal !== tv.chal) held_ok = 1'b0;
            end
            req_valid = 1'b0;
            check("hold_backpressure", {31'd0, held_ok}, 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check($sformatf("hs_valid_%0d", id), {31'd0, resp_valid}, 32'd0);
        check($sformatf("hs_ready_%0d", id), {31'd0, req_ready}, 32'd1);
        check($sformatf("hs_keep_%0d", id), {24'd0, resp, resp_stable}, {24'd0, r0, s0});
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        int c0;
        bit ok;
        bool_quiet: begin end
        tbl[0] = '{chal: 32'h1234_5678, pats: {4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010},
                   exp_resp: 4'b1010};
        tbl[1] = '{chal: 32'hcafe_f00d, pats: {4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001},
                   exp_resp: 4'b0001};
        tbl[2] = '{chal: 32'h0000_0001, pats: {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
                   exp_resp: 4'b0000};
        tbl[3] = '{chal: 32'hffff_ffff, pats: {4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111},
                   exp_resp: 4'b1111};
        // Votes 0..4: 0011, 0101, 1001, 0110, 1100 (pats[4] is leftmost).
        tbl[4] = '{chal: 32'ha5a5_5a5a, pats: {4'b1100, 4'b0110, 4'b1001, 4'b0101, 4'b0011},
                   exp_resp: 4'b0101};

        // Reset state while clr is held low.
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_puf_rst", {31'd0, puf_rst}, 32'd1);
        check("rst_launch", {31'd0, puf_launch}, 32'd0);
        check("rst_chal", puf_chal, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp", {28'd0, resp}, 32'd0);
        check("rst_stable", {28'd0, resp_stable}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vector(tbl[i], i, i == 0);

        // Reset during the third WAIT discards the evaluation.
        arb_in = 4'b1111;
        do_accept(32'h0bad_beef, c0);
        for (int v = 0; v < 3; v++) begin
            wait_launch(32'h0bad_beef, v, ok);
            @(negedge clk);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_puf_rst", {31'd0, puf_rst}, 32'd1);
        check("mid_rst_launch", {31'd0, puf_launch}, 32'd0);
        check("mid_rst_chal", puf_chal, 32'd0);
        check("mid_rst_resp", {27'd0, resp_valid, resp}, 32'd0);
        check("mid_rst_stable", {28'd0, resp_stable}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < LATENCY + 10; k++) begin
                @(negedge clk);
                if (resp_valid || !req_ready) seen = 1'b1;
            end
            check("no_resp_after_rst", {31'd0, seen}, 32'd0);
        end
        rv = tbl[4];
        rv.chal = 32'h7777_1111;
        run_vector(rv, 5, 1'b0);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mpuf_response_ctrl.md
MPUF_RESPONSE_CTRL -- requirements
Module: mpuf_response_ctrl

Interface
REQ-001 SHALL have parameter CW, default 32: challenge width in bits.
REQ-002 SHALL have parameter NL, default 4: number of arbiter levels, one response bit each.
REQ-003 SHALL have parameter NV, default 5: evaluations per challenge for majority vote; odd, at least 1.
REQ-004 SHALL have parameter SETTLE, default 8: cycles waited after launch before sampling; at least 3.
REQ-005 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-006 SHALL have port clr  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  challenge request valid.
REQ-008 SHALL have port req_ready  out  1  block can accept a challenge.
REQ-009 SHALL have port challenge  in  CW  challenge captured on accept.
REQ-010 SHALL have port puf_chal  out  CW  registered challenge driven to all arbiter levels.
REQ-011 SHALL have port puf_rst  out  1  active-high clear of delay lines and arbiter latches.
REQ-012 SHALL have port puf_launch  out  1  single-cycle launch pulse to delay lines.
REQ-013 SHALL have port arb_in  in  NL  raw arbiter outputs, bit i from level i; asynchronous to clk.
REQ-014 SHALL have port resp_valid  out  1  response valid.
REQ-015 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-016 SHALL have port resp  out  NL  majority-voted response.
REQ-017 SHALL have port resp_stable  out  NL  per-bit unanimity mask.

Function
REQ-018 SHALL pass arb_in through a 2-flop synchroniser per bit; all sampling SHALL use the synchronised value.
REQ-019 SHALL implement FSM states IDLE, PREP, LAUNCH, WAIT, SAMPLE, DONE.
REQ-020 SHALL drive req_ready high only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both high.
REQ-021 On accept, SHALL register challenge into puf_chal, clear all vote counters and the vote index, and enter PREP.
REQ-022 puf_chal SHALL remain constant from accept until the next accept.
REQ-023 SHALL assert puf_rst in IDLE, PREP and DONE, and deassert it in LAUNCH, WAIT and SAMPLE.
REQ-024 PREP SHALL last 1 cycle and then enter LAUNCH.
REQ-025 LAUNCH SHALL last 1 cycle with puf_launch high, then enter WAIT; puf_launch SHALL be low in all other states.
REQ-026 WAIT SHALL last exactly SETTLE cycles, then enter SAMPLE.
REQ-027 In SAMPLE, per-bit counter i (width clog2(NV+1)) SHALL increment when synchronised arb_in[i] is 1.
REQ-028 After SAMPLE, SHALL enter PREP if fewer than NV votes are done; otherwise SHALL enter DONE.
REQ-029 On entering DONE, resp[i] SHALL be 1 exactly when count[i] > NV/2 (integer division), and resp_valid SHALL rise.
REQ-030 Latency SHALL be exactly NV*(SETTLE+3) cycles from the accept edge to resp_valid high.
REQ-031 resp, resp_stable and resp_valid SHALL hold unchanged while resp_valid is high and resp_ready is low.
REQ-032 A handshake (resp_valid and resp_ready high) SHALL drop resp_valid and return to IDLE; resp and resp_stable SHALL keep their last values.
REQ-033 req_valid outside IDLE SHALL be ignored, with no effect on state or counters.

Reset
REQ-034 Asserting clr (low) SHALL immediately force state IDLE and clear counters and synchroniser flops, in any state.
REQ-035 Reset values SHALL be: req_ready 1, puf_rst 1, puf_launch 0, puf_chal 0, resp_valid 0, resp 0, resp_stable 0.
REQ-036 Reset mid-evaluation SHALL discard the partial votes; no response SHALL be produced for that challenge.

Configuration
REQ-037 With macro MPUF_STABILITY_EN defined, resp_stable[i] SHALL be set on DONE entry when count[i] is 0 or NV.
REQ-038 Without MPUF_STABILITY_EN, resp_stable SHALL be all-ones in DONE and zero after reset, and no unanimity logic SHALL be synthesised.

Verification
REQ-039 NV=5, SETTLE=8, arb_in=4'b1010 constant, challenge accepted -> resp_valid exactly 55 cycles later; resp=4'b1010; resp_stable=4'b1111.
REQ-040 NV=5, arb_in[0] = 1,1,1,0,0 across votes, others 0 -> resp[0]=1; with MPUF_STABILITY_EN, resp_stable=4'b1110.
REQ-041 resp_ready held low 20 cycles after resp_valid -> resp and resp_valid stable; req_ready stays 0; req_valid pulses ignored.
REQ-042 clr pulsed low during the third WAIT -> outputs at reset values at once; a new challenge gives a full-latency fresh result.
REQ-043 Per vote -> puf_launch is exactly one 1-cycle pulse, preceded by a puf_rst-high PREP cycle, with puf_chal equal to the accepted challenge throughout.
